mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_pkg.sv | 64 ++++++
 rtl/mc_outdec.sv | 102 ++++++++++
 rtl/mc_ctrl.sv | 102 ++++++++++
 tb/tb_mc_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS-style control FSM.
// Holds the opcode constants, the state encoding and the mux/ALU select codes.
// Optional feature macro: MC_ADDI_EN. When it is defined, the IMMEX/IMMWB
// states exist and addi is supported.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Width of the enum encoding; the State port may be wider.
  localparam int unsigned ENC_W = 4;

  typedef enum logic [ENC_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
`ifdef MC_ADDI_EN
    ,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
`endif
  } state_t;

  // Encoding never produced by the next-state logic; stands in for any
  // out-of-range register contents.
  localparam logic [ENC_W-1:0] ENC_UNUSED = 4'hF;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
`ifdef MC_ADDI_EN
      OP_ADDI: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational Moore output decoder for mc_ctrl.
// Inputs : st (current state), mem_rdy (memory handshake, already reset-gated)
// Outputs: datapath control strobes and selects, instr_done pulse.
// Optional feature macro: MC_ADDI_EN (adds IMMEX/IMMWB decode).
module mc_outdec
  import mc_pkg::*;
(
  input  state_t     st,
  input  logic       mem_rdy,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       reg_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_b     = SRCB_REG;
    alu_op        = ALUOP_ADD;
    instr_done    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_rdy;
        ir_write  = mem_rdy;
      end
      S_DECODE: alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_rdy;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle processor control FSM (Moore): state register, next-state
// logic and illegal-opcode detection; outputs decoded by mc_outdec.
// Ports: CLK, RST_N (async active-low), Op (IR[31:26]), Mem_Rdy,
//        datapath controls, Instr_Done, Illegal, State (debug, STATE_W bits).
// Optional feature macro: MC_ADDI_EN (addi support via IMMEX/IMMWB).
// STATE_W must be at least 4.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [5:0]         Op,
  input  logic               Mem_Rdy,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic               RegDst,
  output logic               RegWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic               Instr_Done,
  output logic               Illegal,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] state_q;
  state_t             cur;
  state_t             nxt;
  logic               rdy_gated;

  // Any register value with upper bits set is folded onto an unused
  // encoding so the decoders treat it as unreachable.
  always_comb begin
    if ((state_q >> ENC_W) == '0) cur = state_t'(state_q[ENC_W-1:0]);
    else                          cur = state_t'(ENC_UNUSED);
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH:  nxt = Mem_Rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      nxt = S_IMMEX;
`endif
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR: nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = Mem_Rdy ? S_MEMWB : S_MEMRD;
      S_MEMWR:  nxt = Mem_Rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   nxt = S_ALUWB;
`ifdef MC_ADDI_EN
      S_IMMEX:  nxt = S_IMMWB;
`endif
      default:  nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= STATE_W'(S_FETCH);
    else        state_q <= STATE_W'(nxt);
  end

  // Reset gating keeps the Mem_Rdy-qualified FETCH strobes quiet in reset.
  assign rdy_gated = Mem_Rdy & RST_N;
  assign Illegal   = (cur == S_DECODE) && !op_supported(Op);
  assign State     = state_q;

  mc_outdec u_outdec (
    .st            (cur),
    .mem_rdy       (rdy_gated),
    .pc_write      (PCWrite),
    .pc_write_cond (PCWriteCond),
    .i_or_d        (IorD),
    .mem_read      (MemRead),
    .mem_write     (MemWrite),
    .ir_write      (IRWrite),
    .mem_to_reg    (MemtoReg),
    .alu_src_a     (ALUSrcA),
    .reg_dst       (RegDst),
    .reg_write     (RegWrite),
    .pc_source     (PCSource),
    .alu_src_b     (ALUSrcB),
    .alu_op        (ALUOp),
    .instr_done    (Instr_Done)
  );

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: a table of per-cycle vectors, a latency
// sweep with Mem_Rdy held high, and a running RegWrite/MemWrite monitor.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [5:0] Op;
  logic       Mem_Rdy;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, ALUSrcA, RegDst, RegWrite;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic       Instr_Done, Illegal;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  mc_ctrl #(.STATE_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .Op(Op), .Mem_Rdy(Mem_Rdy),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegDst(RegDst),
    .RegWrite(RegWrite), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .Instr_Done(Instr_Done), .Illegal(Illegal),
    .State(State)
  );

  logic [17:0] got;
  assign got = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, ALUSrcA, RegDst, RegWrite, PCSource, ALUSrcB,
                ALUOp, Instr_Done, Illegal};

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [17:0] o;
  } vec_t;

  vec_t vq[$];

  function automatic logic [17:0] mk(
    input logic pcw, pcwc, iord, mr, mw, irw, m2r, sa, rd, rw,
    input logic [1:0] pcs, sb, aop,
    input logic done, ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, sa, rd, rw, pcs, sb, aop, done, ill};
  endfunction

  task automatic add(input logic r, input logic [5:0] op, input logic rdy,
                     input state_t st, input logic [17:0] o);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.o = o;
    vq.push_back(v);
  endtask

  // Runs one instruction with Mem_Rdy=1 from FETCH; counts cycles up to
  // and including the one showing Instr_Done or Illegal.
  task automatic lat(input logic [5:0] op, input int want, input string nm);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge CLK);
      Op = op;
      Mem_Rdy = 1'b1;
      #1;
      n++;
      if (Instr_Done || Illegal) seen = 1;
    end
    total++;
    if (!seen || n != want) begin
      bad++;
      $display("FAIL lat_%s: got=%0d cycles want=%0d", nm, n, want);
    end
  endtask

  // RegWrite must never repeat on consecutive cycles nor coincide with MemWrite.
  logic prev_rw = 1'b0;
  always @(negedge CLK) begin
    #2;
    if (RST_N === 1'b1) begin
      total++;
      if (RegWrite && (prev_rw || MemWrite)) begin
        bad++;
        $display("FAIL regwrite_rule: RegWrite=%b prev=%b MemWrite=%b", RegWrite, prev_rw, MemWrite);
      end
      prev_rw = RegWrite;
    end else begin
      prev_rw = 1'b0;
    end
  end

  logic [17:0] E_FW, E_FR, E_DEC, E_DIL, E_MA, E_MRD, E_MWW, E_MWR;
  logic [17:0] E_MWB, E_EX, E_AWB, E_IWB, E_BR, E_JMP;
  localparam logic [5:0] OP_BAD = 6'b111111;

  initial begin
    RST_N   = 1'b0;
    Op      = OP_RTYPE;
    Mem_Rdy = 1'b0;

    E_FW  = mk(0,0,0,1,0,0,0,0,0,0, 2'b00,2'b01,2'b00, 0,0);
    E_FR  = mk(1,0,0,1,0,1,0,0,0,0, 2'b00,2'b01,2'b00, 0,0);
    E_DEC = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00, 0,0);
    E_DIL = mk(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00, 0,1);
    E_MA  = mk(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b10,2'b00, 0,0);
    E_MRD = mk(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0);
    E_MWW = mk(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0);
    E_MWR = mk(0,0,1,0,1,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0);
    E_MWB = mk(0,0,0,0,0,0,1,0,0,1, 2'b00,2'b00,2'b00, 1,0);
    E_EX  = mk(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b10, 0,0);
    E_AWB = mk(0,0,0,0,0,0,0,0,1,1, 2'b00,2'b00,2'b00, 1,0);
    E_IWB = mk(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 1,0);
    E_BR  = mk(0,1,0,0,0,0,0,1,0,0, 2'b01,2'b00,2'b01, 1,0);
    E_JMP = mk(1,0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00, 1,0);

    // reset: FETCH outputs only, Mem_Rdy ignored
    add(0, OP_RTYPE, 1, S_FETCH,  E_FW);
    add(0, OP_RTYPE, 0, S_FETCH,  E_FW);
    // lw, no wait states
    add(1, OP_LW,    1, S_FETCH,  E_FR);
    add(1, OP_LW,    1, S_DECODE, E_DEC);
    add(1, OP_LW,    1, S_MEMADR, E_MA);
    add(1, OP_LW,    1, S_MEMRD,  E_MRD);
    add(1, OP_LW,    1, S_MEMWB,  E_MWB);
    // R-type with three FETCH wait cycles; Op changes after DECODE ignored
    add(1, OP_RTYPE, 0, S_FETCH,  E_FW);
    add(1, OP_RTYPE, 0, S_FETCH,  E_FW);
    add(1, OP_RTYPE, 0, S_FETCH,  E_FW);
    add(1, OP_RTYPE, 1, S_FETCH,  E_FR);
    add(1, OP_RTYPE, 1, S_DECODE, E_DEC);
    add(1, OP_LW,    1, S_EXEC,   E_EX);
    add(1, OP_BEQ,   1, S_ALUWB,  E_AWB);
    // beq then j
    add(1, OP_BEQ,   1, S_FETCH,  E_FR);
    add(1, OP_BEQ,   1, S_DECODE, E_DEC);
    add(1, OP_J,     1, S_BRANCH, E_BR);
    add(1, OP_J,     1, S_FETCH,  E_FR);
    add(1, OP_J,     1, S_DECODE, E_DEC);
    add(1, OP_J,     1, S_JUMP,   E_JMP);
    // sw with one MEMWR wait cycle
    add(1, OP_SW,    1, S_FETCH,  E_FR);
    add(1, OP_SW,    1, S_DECODE, E_DEC);
    add(1, OP_SW,    1, S_MEMADR, E_MA);
    add(1, OP_SW,    0, S_MEMWR,  E_MWW);
    add(1, OP_SW,    1, S_MEMWR,  E_MWR);
    // Op resampled in MEMADR: decoded as lw, becomes sw
    add(1, OP_LW,    1, S_FETCH,  E_FR);
    add(1, OP_LW,    1, S_DECODE, E_DEC);
    add(1, OP_SW,    1, S_MEMADR, E_MA);
    add(1, OP_SW,    1, S_MEMWR,  E_MWR);
    // unsupported opcode
    add(1, OP_BAD,   1, S_FETCH,  E_FR);
    add(1, OP_BAD,   1, S_DECODE, E_DIL);
    // addi
    add(1, OP_ADDI,  1, S_FETCH,  E_FR);
`ifdef MC_ADDI_EN
    add(1, OP_ADDI,  1, S_DECODE, E_DEC);
    add(1, OP_ADDI,  1, S_IMMEX,  E_MA);
    add(1, OP_ADDI,  1, S_IMMWB,  E_IWB);
`else
    add(1, OP_ADDI,  1, S_DECODE, E_DIL);
`endif
    // reset while stalled in MEMRD, then a clean R-type
    add(1, OP_LW,    1, S_FETCH,  E_FR);
    add(1, OP_LW,    1, S_DECODE, E_DEC);
    add(1, OP_LW,    1, S_MEMADR, E_MA);
    add(1, OP_LW,    0, S_MEMRD,  E_MRD);
    add(0, OP_LW,    0, S_FETCH,  E_FW);
    add(1, OP_LW,    0, S_FETCH,  E_FW);
    add(1, OP_RTYPE, 1, S_FETCH,  E_FR);
    add(1, OP_RTYPE, 1, S_DECODE, E_DEC);
    add(1, OP_RTYPE, 1, S_EXEC,   E_EX);
    add(1, OP_RTYPE, 1, S_ALUWB,  E_AWB);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      RST_N   = vq[i].rst_n;
      Op      = vq[i].op;
      Mem_Rdy = vq[i].rdy;
      #1;
      total++;
      if (State !== vq[i].st || got !== vq[i].o) begin
        bad++;
        $display("FAIL vec%0d: state=%0d out=%h want state=%0d out=%h",
                 i, State, got, vq[i].st, vq[i].o);
      end
    end

    lat(OP_LW,    5, "lw");
    lat(OP_SW,    4, "sw");
    lat(OP_RTYPE, 4, "rtype");
    lat(OP_BEQ,   3, "beq");
    lat(OP_J,     3, "j");
    lat(OP_BAD,   2, "illegal");
`ifdef MC_ADDI_EN
    lat(OP_ADDI,  4, "addi");
`else
    lat(OP_ADDI,  2, "addi_off");
`endif

    @(negedge CLK);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
